// File: rtl/veri_bellek_denetleyici_if.sv
// Memory-stage data request bus plus the main-memory port of the data memory
// controller. The slave modport is the controller's view. The master modport
// is the view of the requester and of the memory model.
//   request side : onbellekten_oku_i, onbellege_yaz_i, adres_i, veri_i, buyruk_turu_i
//   response side: veri_o, veri_hazir_o, denetim_hazir_o, hata_o
//   main memory  : anabellek_istek_o/yaz_o/adres_o/veri_o/maske_o out,
//                  anabellek_veri_i/gecerli_i in
interface veri_bellek_denetleyici_if;
  logic        onbellekten_oku_i;
  logic        onbellege_yaz_i;
  logic [31:0] adres_i;
  logic [31:0] veri_i;
  logic [2:0]  buyruk_turu_i;
  logic [31:0] veri_o;
  logic        veri_hazir_o;
  logic        denetim_hazir_o;
  logic        hata_o;
  logic        anabellek_istek_o;
  logic        anabellek_yaz_o;
  logic [31:0] anabellek_adres_o;
  logic [31:0] anabellek_veri_o;
  logic [3:0]  anabellek_maske_o;
  logic [31:0] anabellek_veri_i;
  logic        anabellek_gecerli_i;

  modport slave (
    input  onbellekten_oku_i, onbellege_yaz_i, adres_i, veri_i, buyruk_turu_i,
           anabellek_veri_i, anabellek_gecerli_i,
    output veri_o, veri_hazir_o, denetim_hazir_o, hata_o,
           anabellek_istek_o, anabellek_yaz_o, anabellek_adres_o,
           anabellek_veri_o, anabellek_maske_o
  );

  modport master (
    output onbellekten_oku_i, onbellege_yaz_i, adres_i, veri_i, buyruk_turu_i,
           anabellek_veri_i, anabellek_gecerli_i,
    input  veri_o, veri_hazir_o, denetim_hazir_o, hata_o,
           anabellek_istek_o, anabellek_yaz_o, anabellek_adres_o,
           anabellek_veri_o, anabellek_maske_o
  );
endinterface

// File: rtl/veri_bellek_denetleyici.sv
// Data memory controller, the responder end of the memory-stage load/store
// interface. It takes one load or store per transaction and issues it to main
// memory as a word access with a byte mask. It aligns and extends the load data
// and reports completion through denetim_hazir_o.
// Ports: clk_i (rising edge), rst_i (synchronous, active low), and bus (slave
//   modport of veri_bellek_denetleyici_if, which holds all request, response
//   and main-memory signals).
// Parameter: ZAMAN_ASIMI is the number of cycles to wait in an ISTEK state
//   for anabellek_gecerli_i before the transaction is aborted (>= 2).
// Optional feature: define VB_SON_OKUMA_TAMPONU_EN to add a one-entry
//   last-read buffer. A read that hits the buffer completes without a
//   main-memory access.
module veri_bellek_denetleyici #(
  parameter int ZAMAN_ASIMI = 255
) (
  input logic                      clk_i,
  input logic                      rst_i,
  veri_bellek_denetleyici_if.slave bus
);
  localparam int            CW        = $clog2(ZAMAN_ASIMI + 1);
  // Abort in the ISTEK cycle whose increment would make the count reach
  // ZAMAN_ASIMI-1. That gives ZAMAN_ASIMI-1 request cycles in total.
  localparam logic [CW-1:0] SAYAC_SON = CW'(ZAMAN_ASIMI - 2);

  typedef enum logic [1:0] {BOSTA, OKU_ISTEK, YAZ_ISTEK, TAMAM} durum_t;

  durum_t        durum_q, durum_d;
  logic [CW-1:0] sayac_q;
  logic [1:0]    bayt_q;   // low address bits of the transaction in flight
  logic [2:0]    tur_q;    // funct3 of the transaction in flight
  logic [31:0]   veri_q;
  logic          veri_hazir_q, hata_q, istek_q, yaz_q;
  logic [31:0]   adres_q, aveli_q;
  logic [3:0]    maske_q;
  logic          gir, zaman_asimi, hazir;
  logic [3:0]    maske_hesap;
  logic [31:0]   veri_cogalt;
  wire           istek_durum = (durum_q == OKU_ISTEK) || (durum_q == YAZ_ISTEK);

`ifdef VB_SON_OKUMA_TAMPONU_EN
  logic          tampon_gecerli_q, tampon_isabet;
  logic [29:0]   tampon_adres_q;
  logic [31:0]   tampon_veri_q;
`endif

  function automatic logic [31:0] hizala(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = a[1] ? (a[0] ? w[31:24] : w[23:16]) : (a[0] ? w[15:8] : w[7:0]);
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  hizala = {{24{b[7]}}, b};
      3'b001:  hizala = {{16{h[15]}}, h};
      3'b100:  hizala = {24'b0, b};
      3'b101:  hizala = {16'b0, h};
      default: hizala = w;
    endcase
  endfunction

  always_comb begin
    case (bus.buyruk_turu_i)
      3'b000:  begin maske_hesap = 4'b0001 << bus.adres_i[1:0]; veri_cogalt = {4{bus.veri_i[7:0]}}; end
      3'b001:  begin maske_hesap = bus.adres_i[1] ? 4'b1100 : 4'b0011; veri_cogalt = {2{bus.veri_i[15:0]}}; end
      default: begin maske_hesap = 4'b1111; veri_cogalt = bus.veri_i; end
    endcase
  end

  always_comb begin
    durum_d     = durum_q;
    gir         = 1'b0;
    zaman_asimi = 1'b0;
    hazir       = 1'b0;
`ifdef VB_SON_OKUMA_TAMPONU_EN
    tampon_isabet = 1'b0;
`endif
    case (durum_q)
      BOSTA: begin
        hazir = !(bus.onbellekten_oku_i || bus.onbellege_yaz_i);
        if (bus.onbellege_yaz_i) begin        // a write wins when both are requested
          durum_d = YAZ_ISTEK;
          gir     = 1'b1;
        end else if (bus.onbellekten_oku_i) begin
`ifdef VB_SON_OKUMA_TAMPONU_EN
          if (tampon_gecerli_q && tampon_adres_q == bus.adres_i[31:2]) begin
            durum_d       = TAMAM;
            tampon_isabet = 1'b1;
          end else begin
            durum_d = OKU_ISTEK;
            gir     = 1'b1;
          end
`else
          durum_d = OKU_ISTEK;
          gir     = 1'b1;
`endif
        end
      end
      OKU_ISTEK, YAZ_ISTEK: begin
        if (bus.anabellek_gecerli_i) durum_d = TAMAM;
        else if (sayac_q == SAYAC_SON) begin
          durum_d     = TAMAM;
          zaman_asimi = 1'b1;
        end
      end
      TAMAM: begin
        hazir   = 1'b1;
        durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q      <= BOSTA;
      sayac_q      <= '0;
      bayt_q       <= '0;
      tur_q        <= '0;
      veri_q       <= '0;
      veri_hazir_q <= 1'b0;
      hata_q       <= 1'b0;
      istek_q      <= 1'b0;
      yaz_q        <= 1'b0;
      adres_q      <= '0;
      aveli_q      <= '0;
      maske_q      <= '0;
`ifdef VB_SON_OKUMA_TAMPONU_EN
      tampon_gecerli_q <= 1'b0;
      tampon_adres_q   <= '0;
      tampon_veri_q    <= '0;
`endif
    end else begin
      durum_q      <= durum_d;
      veri_hazir_q <= 1'b0;
      hata_q       <= 1'b0;
      if (gir) begin
        istek_q <= 1'b1;
        yaz_q   <= bus.onbellege_yaz_i;
        adres_q <= {bus.adres_i[31:2], 2'b00};
        maske_q <= bus.onbellege_yaz_i ? maske_hesap : 4'b0000;
        aveli_q <= veri_cogalt;
        bayt_q  <= bus.adres_i[1:0];
        tur_q   <= bus.buyruk_turu_i;
        sayac_q <= '0;
      end
      if (istek_durum) begin
        sayac_q <= sayac_q + 1'b1;
        if (bus.anabellek_gecerli_i) begin
          istek_q <= 1'b0;
          if (!yaz_q) begin
            veri_q       <= hizala(bus.anabellek_veri_i, bayt_q, tur_q);
            veri_hazir_q <= 1'b1;
`ifdef VB_SON_OKUMA_TAMPONU_EN
            tampon_gecerli_q <= 1'b1;
            tampon_adres_q   <= adres_q[31:2];
            tampon_veri_q    <= bus.anabellek_veri_i;
          end else if (tampon_adres_q == adres_q[31:2]) begin
            tampon_gecerli_q <= 1'b0;   // keep the buffer coherent with memory
`endif
          end
        end else if (zaman_asimi) begin
          istek_q <= 1'b0;
          hata_q  <= 1'b1;
          veri_q  <= '0;
`ifdef VB_SON_OKUMA_TAMPONU_EN
          tampon_gecerli_q <= 1'b0;
`endif
        end
      end
`ifdef VB_SON_OKUMA_TAMPONU_EN
      if (tampon_isabet) begin
        veri_q       <= hizala(tampon_veri_q, bus.adres_i[1:0], bus.buyruk_turu_i);
        veri_hazir_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.veri_o            = veri_q;
  assign bus.veri_hazir_o      = veri_hazir_q;
  assign bus.denetim_hazir_o   = hazir;
  assign bus.hata_o            = hata_q;
  assign bus.anabellek_istek_o = istek_q;
  assign bus.anabellek_yaz_o   = yaz_q;
  assign bus.anabellek_adres_o = adres_q;
  assign bus.anabellek_veri_o  = aveli_q;
  assign bus.anabellek_maske_o = maske_q;
endmodule

// File: tb/tb_veri_bellek_denetleyici.sv
module tb_veri_bellek_denetleyici;
  localparam int ZA = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  veri_bellek_denetleyici_if bus ();

  veri_bellek_denetleyici #(.ZAMAN_ASIMI(ZA)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_on = 1'b0;
  // expected outputs for the current cycle
  logic        e_istek = 0, e_yaz = 0, e_vhazir = 0, e_dhazir = 1, e_hata = 0;
  logic [31:0] e_adres = 0, e_aveli = 0, e_veri = 0;
  logic [3:0]  e_maske = 0;
  // observations gathered by the compare process
  int cnt_dlow = 0, cnt_istek = 0, cnt_vh = 0, cnt_hata = 0;
  logic [3:0]  son_maske = 0;
  logic [31:0] son_aveli = 0, son_adres = 0;
  logic        son_yaz = 0;
  // model of the last-read buffer
  bit          m_tv = 0;
  logic [29:0] m_tadr = 0;
  logic [31:0] m_tdata = 0;

  task automatic kontrol(input string ad, input logic [31:0] g, input logic [31:0] b);
    checks++;
    if (g !== b) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", ad, g, b, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int a, input logic [2:0] f);
    logic [31:0] v;
    case (f)
      3'b000, 3'b100: begin
        v = (w >> (8 * a)) & 32'hFF;
        if (f == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * (a / 2))) & 32'hFFFF;
        if (f == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_mask(input int a, input logic [2:0] f);
    if (f == 3'b000) return 4'(1 << a);
    if (f == 3'b001) return (a >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_rep(input logic [31:0] d, input logic [2:0] f);
    if (f == 3'b000) return (d & 32'hFF) * 32'h0101_0101;
    if (f == 3'b001) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // single compare process: every cycle once checking is enabled
  always @(negedge clk) begin
    if (chk_on) begin
      kontrol("istek", bus.anabellek_istek_o, e_istek);
      kontrol("denetim_hazir", bus.denetim_hazir_o, e_dhazir);
      kontrol("veri_hazir", bus.veri_hazir_o, e_vhazir);
      kontrol("hata", bus.hata_o, e_hata);
      kontrol("veri", bus.veri_o, e_veri);
      if (e_istek) begin
        kontrol("an_yaz", bus.anabellek_yaz_o, e_yaz);
        kontrol("an_adres", bus.anabellek_adres_o, e_adres);
        kontrol("an_maske", bus.anabellek_maske_o, e_maske);
        kontrol("an_veri", bus.anabellek_veri_o, e_aveli);
      end
      if (bus.denetim_hazir_o === 1'b0) cnt_dlow++;
      if (bus.veri_hazir_o === 1'b1) cnt_vh++;
      if (bus.hata_o === 1'b1) cnt_hata++;
      if (bus.anabellek_istek_o === 1'b1) begin
        cnt_istek++;
        son_maske = bus.anabellek_maske_o;
        son_aveli = bus.anabellek_veri_o;
        son_adres = bus.anabellek_adres_o;
        son_yaz   = bus.anabellek_yaz_o;
      end
    end
  end

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic bosta_bekle();
    bus.onbellekten_oku_i = 0; bus.onbellege_yaz_i = 0; bus.anabellek_gecerli_i = 0;
    e_istek = 0; e_dhazir = 1; e_vhazir = 0; e_hata = 0;
  endtask

  // One transaction; bekle < 0 means memory never answers.
  task automatic islem(input bit yz, input bit ok, input logic [31:0] adr, input logic [31:0] d,
                       input logic [2:0] f, input int bekle, input logic [31:0] w);
    bit hit;
    int n;
    cnt_dlow = 0; cnt_istek = 0; cnt_vh = 0; cnt_hata = 0;
    bus.onbellekten_oku_i = ok; bus.onbellege_yaz_i = yz;
    bus.adres_i = adr; bus.veri_i = d; bus.buyruk_turu_i = f;
    e_istek = 0; e_vhazir = 0; e_hata = 0; e_dhazir = 0;
    hit = !yz && m_tv && (m_tadr == adr[31:2]);
    adim();
    if (hit) begin
      e_dhazir = 1; e_vhazir = 1; e_veri = ref_load(m_tdata, int'(adr[1:0]), f);
    end else begin
      n = (bekle < 0) ? ZA - 1 : bekle + 1;
      e_istek = 1; e_yaz = yz; e_adres = {adr[31:2], 2'b00};
      e_maske = yz ? ref_mask(int'(adr[1:0]), f) : 4'h0;
      e_aveli = ref_rep(d, f);
      for (int i = 0; i < n; i++) begin
        bus.anabellek_gecerli_i = (bekle >= 0) && (i == n - 1);
        bus.anabellek_veri_i    = bus.anabellek_gecerli_i ? w : 32'hDEAD_BEEF;
        adim();
      end
      bus.anabellek_gecerli_i = 0;
      e_istek = 0; e_dhazir = 1;
      if (bekle < 0) begin
        e_hata = 1; e_veri = 0; m_tv = 0;
      end else if (!yz) begin
        e_vhazir = 1; e_veri = ref_load(w, int'(adr[1:0]), f);
`ifdef VB_SON_OKUMA_TAMPONU_EN
        m_tv = 1; m_tadr = adr[31:2]; m_tdata = w;
`endif
      end else if (m_tadr == adr[31:2]) m_tv = 0;
    end
    adim();
    bosta_bekle();
    adim();
  endtask

  initial begin
    bus.onbellekten_oku_i = 0; bus.onbellege_yaz_i = 0; bus.adres_i = 0; bus.veri_i = 0;
    bus.buyruk_turu_i = 0; bus.anabellek_veri_i = 0; bus.anabellek_gecerli_i = 0;
    adim();
    chk_on = 1;            // reset state: idle, everything cleared
    adim();
    rst = 1;
    adim();

    // LW with three wait cycles
    islem(0, 1, 32'h100, 0, 3'b010, 3, 32'h8081_8283);
    kontrol("lw_veri", bus.veri_o, 32'h8081_8283);
    kontrol("lw_stall_cycles", cnt_dlow, 5);
    kontrol("lw_hazir_pulse", cnt_vh, 1);
    // sub-word loads on the same word
    islem(0, 1, 32'h103, 0, 3'b000, 0, 32'h8081_8283);
    kontrol("lb", bus.veri_o, 32'hFFFF_FF80);
    islem(0, 1, 32'h103, 0, 3'b100, 0, 32'h8081_8283);
    kontrol("lbu", bus.veri_o, 32'h0000_0080);
    islem(0, 1, 32'h102, 0, 3'b001, 0, 32'h8081_8283);
    kontrol("lh", bus.veri_o, 32'hFFFF_8081);
    islem(0, 1, 32'h102, 0, 3'b101, 1, 32'h8081_8283);
    kontrol("lhu", bus.veri_o, 32'h0000_8081);
    islem(0, 1, 32'h500, 0, 3'b010, 1, 32'h1234_5678);
    islem(0, 1, 32'h501, 0, 3'b000, 0, 32'h1234_5678);
    islem(0, 1, 32'h502, 0, 3'b001, 0, 32'h1234_5678);
    kontrol("lh_pos", bus.veri_o, 32'h0000_1234);
    islem(0, 1, 32'h503, 0, 3'b011, 0, 32'h1234_5678);
    kontrol("undef_as_w", bus.veri_o, 32'h1234_5678);
    // stores
    islem(1, 0, 32'h201, 32'h0000_00AB, 3'b000, 2, 0);
    kontrol("sb_maske", son_maske, 4'b0010);
    kontrol("sb_veri", son_aveli, 32'hABAB_ABAB);
    kontrol("sb_adres", son_adres, 32'h200);
    kontrol("sb_yaz", son_yaz, 1);
    islem(1, 0, 32'h202, 32'h1234_CDEF, 3'b001, 0, 0);
    kontrol("sh_maske", son_maske, 4'b1100);
    islem(1, 0, 32'h203, 32'h0000_0055, 3'b000, 0, 0);
    islem(1, 0, 32'h201, 32'h0000_BEEF, 3'b001, 0, 0);   // misaligned SH: a[0] ignored
    islem(1, 1, 32'h204, 32'hCAFE_F00D, 3'b010, 1, 0);   // both requests -> write
    kontrol("both_is_write", son_yaz, 1);
    // timeout
    islem(0, 1, 32'h600, 0, 3'b010, -1, 0);
    kontrol("to_istek_cycles", cnt_istek, 7);
    kontrol("to_hata_pulse", cnt_hata, 1);
    kontrol("to_no_hazir", cnt_vh, 0);
    islem(0, 1, 32'h600, 0, 3'b010, 0, 32'hA5A5_0001);
    kontrol("after_to", bus.veri_o, 32'hA5A5_0001);

    // reset while in OKU_ISTEK
    cnt_vh = 0;
    bus.onbellekten_oku_i = 1; bus.adres_i = 32'h700; bus.veri_i = 0; bus.buyruk_turu_i = 3'b010;
    e_dhazir = 0;
    adim();
    e_istek = 1; e_yaz = 0; e_adres = 32'h700; e_maske = 0; e_aveli = 0;
    adim();
    rst = 0;
    adim();
    rst = 1; bus.onbellekten_oku_i = 0; bus.anabellek_gecerli_i = 1;
    bus.anabellek_veri_i = 32'h1111_1111;
    e_istek = 0; e_dhazir = 1; e_veri = 0; m_tv = 0;
    adim();
    bus.anabellek_gecerli_i = 0;
    adim();
    adim();
    kontrol("rst_no_hazir", cnt_vh, 0);

    // last-read buffer behaviour
    islem(0, 1, 32'h300, 0, 3'b010, 0, 32'h0BAD_CAFE);
    islem(0, 1, 32'h300, 0, 3'b010, 0, 32'h0BAD_CAFE);
`ifdef VB_SON_OKUMA_TAMPONU_EN
    kontrol("hit_no_istek", cnt_istek, 0);
    kontrol("hit_stall_cycles", cnt_dlow, 1);
`else
    kontrol("miss_istek", cnt_istek, 1);
`endif
    islem(1, 0, 32'h300, 32'h1357_2468, 3'b010, 0, 0);
    islem(0, 1, 32'h300, 0, 3'b010, 0, 32'h1357_2468);
    kontrol("reread_istek", cnt_istek, 1);
    kontrol("reread_veri", bus.veri_o, 32'h1357_2468);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
